// File: rtl/alu_share_arbiter_pkg.sv
// Shared definitions for the ALU share arbiter: opcode encodings and
// the result-slot state type.
package alu_pkg;

    localparam int ALU_OP_WIDTH = 6;

    localparam logic [ALU_OP_WIDTH-1:0] ALU_ADD   = 6'd0;
    localparam logic [ALU_OP_WIDTH-1:0] ALU_PASSA = 6'd1;
    localparam logic [ALU_OP_WIDTH-1:0] ALU_BEQ   = 6'd2;
    localparam logic [ALU_OP_WIDTH-1:0] ALU_BNE   = 6'd3;
    localparam logic [ALU_OP_WIDTH-1:0] ALU_SLT   = 6'd4;
    localparam logic [ALU_OP_WIDTH-1:0] ALU_SGE   = 6'd5;
    localparam logic [ALU_OP_WIDTH-1:0] ALU_SLTU  = 6'd6;
    localparam logic [ALU_OP_WIDTH-1:0] ALU_SGEU  = 6'd7;
    localparam logic [ALU_OP_WIDTH-1:0] ALU_XOR   = 6'd8;
    localparam logic [ALU_OP_WIDTH-1:0] ALU_OR    = 6'd9;
    localparam logic [ALU_OP_WIDTH-1:0] ALU_AND   = 6'd10;
    localparam logic [ALU_OP_WIDTH-1:0] ALU_SLL   = 6'd11;
    localparam logic [ALU_OP_WIDTH-1:0] ALU_SRL   = 6'd12;
    localparam logic [ALU_OP_WIDTH-1:0] ALU_SRA   = 6'd13;
    localparam logic [ALU_OP_WIDTH-1:0] ALU_SUB   = 6'd14;

    // The one-entry result slot either holds a result or does not.
    typedef enum logic {
        SLOT_EMPTY = 1'b0,
        SLOT_FULL  = 1'b1
    } slot_state_t;

endpackage

// File: rtl/alu_share_arbiter_if.sv
// Request/response bundle between the requesting pipeline stages (master)
// and the shared-ALU arbiter (slave).
interface alu_share_arbiter_if #(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_REQ    = 2,
    parameter int ID_WIDTH   = 2
);
    import alu_pkg::*;

    logic [NUM_REQ-1:0]              req_valid;
    logic [NUM_REQ-1:0]              req_ready;
    logic [ALU_OP_WIDTH*NUM_REQ-1:0] req_op;
    logic [DATA_WIDTH*NUM_REQ-1:0]   req_a;
    logic [DATA_WIDTH*NUM_REQ-1:0]   req_b;
    logic [NUM_REQ-1:0]              rsp_valid;
    logic [NUM_REQ-1:0]              rsp_ready;
    logic [DATA_WIDTH-1:0]           rsp_result;
    logic [ID_WIDTH-1:0]             rsp_id;

    modport master (
        output req_valid, req_op, req_a, req_b, rsp_ready,
        input  req_ready, rsp_valid, rsp_result, rsp_id
    );

    modport slave (
        input  req_valid, req_op, req_a, req_b, rsp_ready,
        output req_ready, rsp_valid, rsp_result, rsp_id
    );

endinterface

// File: rtl/alu_share_arbiter_rr.sv
// Grant selector for the shared ALU. Round-robin by default; defining
// ALU_SHARE_FIXED_PRIO_EN switches to fixed lowest-index priority and
// removes the pointer register (and with it the clock/reset ports).
module alu_rr_arbiter #(
    parameter int NUM_REQ  = 2,
    parameter int ID_WIDTH = 2
) (
`ifndef ALU_SHARE_FIXED_PRIO_EN
    input  logic                clock,
    input  logic                reset,
`endif
    input  logic                i_enable,
    input  logic [NUM_REQ-1:0]  i_req,
    output logic [NUM_REQ-1:0]  o_grant,
    output logic [ID_WIDTH-1:0] o_grantId
);

    logic w_found;

`ifndef ALU_SHARE_FIXED_PRIO_EN
    logic [ID_WIDTH-1:0] r_ptr;
    logic [ID_WIDTH-1:0] w_nextPtr;

    // Search from the pointer upward with wrap; the first valid requester wins.
    always_comb begin
        o_grant   = '0;
        o_grantId = '0;
        w_found   = 1'b0;
        w_nextPtr = r_ptr;
        if (i_enable) begin
            for (int k = 0; k < NUM_REQ; k++) begin
                for (int j = 0; j < NUM_REQ; j++) begin
                    if (!w_found && i_req[j] && (j == ((int'(r_ptr) + k) % NUM_REQ))) begin
                        w_found    = 1'b1;
                        o_grant[j] = 1'b1;
                        o_grantId  = ID_WIDTH'(j);
                        w_nextPtr  = ID_WIDTH'((j + 1) % NUM_REQ);
                    end
                end
            end
        end
    end

    // Move the pointer just past the winner; hold it when nobody is granted.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_ptr <= '0;
        end else if (w_found) begin
            r_ptr <= w_nextPtr;
        end
    end
`else
    // Lowest-index valid requester always wins.
    always_comb begin
        o_grant   = '0;
        o_grantId = '0;
        w_found   = 1'b0;
        if (i_enable) begin
            for (int j = 0; j < NUM_REQ; j++) begin
                if (!w_found && i_req[j]) begin
                    w_found    = 1'b1;
                    o_grant[j] = 1'b1;
                    o_grantId  = ID_WIDTH'(j);
                end
            end
        end
    end
`endif

endmodule

// File: rtl/alu_share_arbiter.sv
// Shares a single ALU between NUM_REQ requesters with a one-entry
// registered result slot. Arbitration mode is selected by the macro
// ALU_SHARE_FIXED_PRIO_EN (undefined: round-robin, defined: fixed priority).
module alu_share_arbiter
    import alu_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_REQ    = 2,
    parameter int ID_WIDTH   = 2
) (
    input  logic               clock,
    input  logic               reset,
    alu_share_arbiter_if.slave io_bus
);

    slot_state_t             r_state;
    slot_state_t             w_nextState;
    logic [DATA_WIDTH-1:0]   r_rspResult;
    logic [ID_WIDTH-1:0]     r_rspId;

    logic                    w_drain;
    logic                    w_slotFree;
    logic                    w_accept;
    logic [NUM_REQ-1:0]      w_grant;
    logic [ID_WIDTH-1:0]     w_grantId;
    logic [ALU_OP_WIDTH-1:0] w_op;
    logic [DATA_WIDTH-1:0]   w_opA;
    logic [DATA_WIDTH-1:0]   w_opB;
    logic [DATA_WIDTH-1:0]   w_aluResult;
    logic [4:0]              w_shamt;

    // The slot drains when its owner takes the result; only the owner's ready bit counts.
    always_comb begin
        w_drain = 1'b0;
        if (r_state == SLOT_FULL) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if ((r_rspId == ID_WIDTH'(i)) && io_bus.rsp_ready[i]) begin
                    w_drain = 1'b1;
                end
            end
        end
    end

    // Grants are blocked during reset so req_ready reads zero while it is asserted.
    assign w_slotFree = reset & ((r_state == SLOT_EMPTY) | w_drain);
    assign w_accept   = |(io_bus.req_valid & w_grant);

    alu_rr_arbiter #(
        .NUM_REQ  (NUM_REQ),
        .ID_WIDTH (ID_WIDTH)
    ) u_arbiter (
`ifndef ALU_SHARE_FIXED_PRIO_EN
        .clock     (clock),
        .reset     (reset),
`endif
        .i_enable  (w_slotFree),
        .i_req     (io_bus.req_valid),
        .o_grant   (w_grant),
        .o_grantId (w_grantId)
    );

    // Route the granted requester's opcode and operands into the ALU.
    always_comb begin
        w_op  = '0;
        w_opA = '0;
        w_opB = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_grant[i]) begin
                w_op  = io_bus.req_op[ALU_OP_WIDTH*i +: ALU_OP_WIDTH];
                w_opA = io_bus.req_a[DATA_WIDTH*i +: DATA_WIDTH];
                w_opB = io_bus.req_b[DATA_WIDTH*i +: DATA_WIDTH];
            end
        end
    end

    assign w_shamt = w_opB[4:0];

    // The shared ALU; unknown opcodes yield zero but still complete the handshake.
    always_comb begin
        w_aluResult = '0;
        case (w_op)
            ALU_ADD:   w_aluResult = w_opA + w_opB;
            ALU_PASSA: w_aluResult = w_opA;
            ALU_BEQ:   w_aluResult = DATA_WIDTH'(w_opA == w_opB);
            ALU_BNE:   w_aluResult = DATA_WIDTH'(w_opA != w_opB);
            ALU_SLT:   w_aluResult = DATA_WIDTH'($signed(w_opA) <  $signed(w_opB));
            ALU_SGE:   w_aluResult = DATA_WIDTH'($signed(w_opA) >= $signed(w_opB));
            ALU_SLTU:  w_aluResult = DATA_WIDTH'(w_opA <  w_opB);
            ALU_SGEU:  w_aluResult = DATA_WIDTH'(w_opA >= w_opB);
            ALU_XOR:   w_aluResult = w_opA ^ w_opB;
            ALU_OR:    w_aluResult = w_opA | w_opB;
            ALU_AND:   w_aluResult = w_opA & w_opB;
            ALU_SLL:   w_aluResult = w_opA << w_shamt;
            ALU_SRL:   w_aluResult = w_opA >> w_shamt;
            ALU_SRA:   w_aluResult = $signed(w_opA) >>> w_shamt;
            ALU_SUB:   w_aluResult = w_opA - w_opB;
            default:   w_aluResult = '0;
        endcase
    end

    // Slot state register; reset drops any in-flight result.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state <= SLOT_EMPTY;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Fill on accept, empty on a drain with no new accept, stay full otherwise.
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            SLOT_EMPTY: if (w_accept) w_nextState = SLOT_FULL;
            SLOT_FULL:  if (w_drain && !w_accept) w_nextState = SLOT_EMPTY;
            default:    w_nextState = SLOT_EMPTY;
        endcase
    end

    // Capture the ALU result and its owner on every accept.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_rspResult <= '0;
            r_rspId     <= '0;
        end else if (w_accept) begin
            r_rspResult <= w_aluResult;
            r_rspId     <= w_grantId;
        end
    end

    // Drive the bus: grants go out directly, rsp_valid is the owner's one-hot while full.
    always_comb begin
        io_bus.req_ready  = w_grant;
        io_bus.rsp_result = r_rspResult;
        io_bus.rsp_id     = r_rspId;
        io_bus.rsp_valid  = '0;
        if (r_state == SLOT_FULL) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                io_bus.rsp_valid[i] = (r_rspId == ID_WIDTH'(i));
            end
        end
    end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed self-checking bench for alu_share_arbiter with two requesters.
// Expectations follow ALU_SHARE_FIXED_PRIO_EN when it is defined.
module tb_alu_share_arbiter;

    localparam int DATA_WIDTH = 32;
    localparam int NUM_REQ    = 2;
    localparam int ID_WIDTH   = 2;

    logic clock;
    logic reset;

    int assertCount = 0;
    int failCount   = 0;

    alu_share_arbiter_if #(
        .DATA_WIDTH (DATA_WIDTH),
        .NUM_REQ    (NUM_REQ),
        .ID_WIDTH   (ID_WIDTH)
    ) busIf ();

    alu_share_arbiter #(
        .DATA_WIDTH (DATA_WIDTH),
        .NUM_REQ    (NUM_REQ),
        .ID_WIDTH   (ID_WIDTH)
    ) dut (
        .clock  (clock),
        .reset  (reset),
        .io_bus (busIf.slave)
    );

    // Free-running 10 ns clock.
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Hard time limit so the run always ends.
    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    // Compare one observed value against its expected value and count it.
    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        assertCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Drive one full set of requester inputs.
    task automatic applyStimulus(input logic [1:0] valid,
                                 input logic [5:0] op0, input logic [31:0] a0, input logic [31:0] b0,
                                 input logic [5:0] op1, input logic [31:0] a1, input logic [31:0] b1,
                                 input logic [1:0] rspReady);
        busIf.req_valid = valid;
        busIf.req_op    = {op1, op0};
        busIf.req_a     = {a1, a0};
        busIf.req_b     = {b1, b0};
        busIf.rsp_ready = rspReady;
    endtask

    // Move to just after the next rising edge.
    task automatic nextCycle();
        @(posedge clock);
        #1;
    endtask

    // One req0-only operation: grant in the same cycle, result after the edge.
    task automatic runSingle0(input string tag, input logic [5:0] op, input logic [31:0] a,
                              input logic [31:0] b, input logic [31:0] expected);
        applyStimulus(2'b01, op, a, b, 6'd0, 32'd0, 32'd0, 2'b11);
        #1;
        checkOutput({tag, "_ready"}, 32'(busIf.req_ready), 32'h1);
        nextCycle();
        checkOutput({tag, "_valid"}, 32'(busIf.rsp_valid), 32'h1);
        checkOutput({tag, "_result"}, busIf.rsp_result, expected);
    endtask

    initial begin
        logic [1:0] expGrant;

        // Reset with both requesters asking: nothing may be granted.
        reset = 1'b0;
        applyStimulus(2'b11, 6'd0, 32'd1, 32'd1, 6'd0, 32'd2, 32'd2, 2'b11);
        #2;
        checkOutput("rst_req_ready", 32'(busIf.req_ready), 32'h0);
        checkOutput("rst_rsp_valid", 32'(busIf.rsp_valid), 32'h0);
        checkOutput("rst_rsp_result", busIf.rsp_result, 32'h0);
        checkOutput("rst_rsp_id", 32'(busIf.rsp_id), 32'h0);
        applyStimulus(2'b00, 6'd0, 32'd0, 32'd0, 6'd0, 32'd0, 32'd0, 2'b11);
        nextCycle();
        nextCycle();
        reset = 1'b1;
        nextCycle();

        // Single request from req0: ADD 5+7.
        applyStimulus(2'b01, 6'd0, 32'd5, 32'd7, 6'd0, 32'd0, 32'd0, 2'b11);
        #1;
        checkOutput("single_ready", 32'(busIf.req_ready), 32'h1);
        nextCycle();
        checkOutput("single_valid", 32'(busIf.rsp_valid), 32'h1);
        checkOutput("single_result", busIf.rsp_result, 32'd12);
        checkOutput("single_id", 32'(busIf.rsp_id), 32'd0);

        // Single request from req1: SUB 10-3; pointer returns to 0 afterwards.
        applyStimulus(2'b10, 6'd0, 32'd0, 32'd0, 6'd14, 32'd10, 32'd3, 2'b11);
        #1;
        checkOutput("req1_ready", 32'(busIf.req_ready), 32'h2);
        nextCycle();
        checkOutput("req1_valid", 32'(busIf.rsp_valid), 32'h2);
        checkOutput("req1_result", busIf.rsp_result, 32'd7);
        checkOutput("req1_id", 32'(busIf.rsp_id), 32'd1);

        // Contention: req0 XOR, req1 SUB, both valid every cycle.
        applyStimulus(2'b11, 6'd8, 32'h0000F0F0, 32'h00000FF0, 6'd14, 32'd10, 32'd3, 2'b11);
        for (int i = 0; i < 4; i++) begin
            #1;
`ifdef ALU_SHARE_FIXED_PRIO_EN
            expGrant = 2'b01;
`else
            expGrant = (i % 2 == 0) ? 2'b01 : 2'b10;
`endif
            checkOutput("cont_ready", 32'(busIf.req_ready), 32'(expGrant));
            nextCycle();
            checkOutput("cont_id", 32'(busIf.rsp_id), (expGrant == 2'b01) ? 32'd0 : 32'd1);
            checkOutput("cont_result", busIf.rsp_result, (expGrant == 2'b01) ? 32'h0000FF00 : 32'd7);
        end

        // Fill the slot for req0 (ADD 100+23).
        applyStimulus(2'b01, 6'd0, 32'd100, 32'd23, 6'd14, 32'd10, 32'd3, 2'b11);
        nextCycle();
        checkOutput("bp_fill_result", busIf.rsp_result, 32'd123);

        // Hold: owner not ready (non-owner ready is ignored), both requesting.
        applyStimulus(2'b11, 6'd0, 32'd100, 32'd23, 6'd14, 32'd10, 32'd3, 2'b10);
        for (int i = 0; i < 3; i++) begin
            #1;
            checkOutput("bp_hold_ready", 32'(busIf.req_ready), 32'h0);
            checkOutput("bp_hold_result", busIf.rsp_result, 32'd123);
            checkOutput("bp_hold_valid", 32'(busIf.rsp_valid), 32'h1);
            nextCycle();
        end

        // Release: drain and a new accept on the same edge.
        busIf.rsp_ready = 2'b01;
        #1;
`ifdef ALU_SHARE_FIXED_PRIO_EN
        expGrant = 2'b01;
`else
        expGrant = 2'b10;
`endif
        checkOutput("bp_release_ready", 32'(busIf.req_ready), 32'(expGrant));
        nextCycle();
        checkOutput("bp_release_valid", 32'(busIf.rsp_valid), 32'(expGrant));
        checkOutput("bp_release_result", busIf.rsp_result, (expGrant == 2'b01) ? 32'd123 : 32'd7);

        // Datapath corners through req0.
        runSingle0("sra", 6'd13, 32'h80000000, 32'd4, 32'hF8000000);
        runSingle0("slt", 6'd4, 32'hFFFFFFFF, 32'd0, 32'd1);
        runSingle0("sltu", 6'd6, 32'hFFFFFFFF, 32'd0, 32'd0);
        runSingle0("sll", 6'd11, 32'd1, 32'd35, 32'd8);
        runSingle0("srl", 6'd12, 32'h80000000, 32'd4, 32'h08000000);
        runSingle0("beq", 6'd2, 32'd5, 32'd5, 32'd1);
        runSingle0("op63", 6'd63, 32'd5, 32'd7, 32'd0);

        // Reset mid-op: slot full for req0, owner stalled, reset dropped between edges.
        applyStimulus(2'b11, 6'd0, 32'd1, 32'd2, 6'd0, 32'd3, 32'd4, 2'b00);
        #1;
        checkOutput("midrst_pre_ready", 32'(busIf.req_ready), 32'h0);
        reset = 1'b0;
        #1;
        checkOutput("midrst_valid", 32'(busIf.rsp_valid), 32'h0);
        checkOutput("midrst_result", busIf.rsp_result, 32'h0);
        checkOutput("midrst_id", 32'(busIf.rsp_id), 32'h0);
        checkOutput("midrst_ready", 32'(busIf.req_ready), 32'h0);
        nextCycle();
        reset = 1'b1;
        busIf.rsp_ready = 2'b11;

        // After reset both requesters contend for 4 cycles; req0 must win first.
        for (int i = 0; i < 4; i++) begin
            #1;
`ifdef ALU_SHARE_FIXED_PRIO_EN
            expGrant = 2'b01;
`else
            expGrant = (i % 2 == 0) ? 2'b01 : 2'b10;
`endif
            checkOutput("post_rst_ready", 32'(busIf.req_ready), 32'(expGrant));
            nextCycle();
            checkOutput("post_rst_id", 32'(busIf.rsp_id), (expGrant == 2'b01) ? 32'd0 : 32'd1);
            checkOutput("post_rst_result", busIf.rsp_result, (expGrant == 2'b01) ? 32'd3 : 32'd7);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
